// File: rtl/paint_pkg.sv
// Shared types and constants for the cursor overlay engine.
// CURSOR_BLINK_EN adds the BLINK state to the FSM encoding.
package paint_pkg;

  localparam int COLOR_W       = 8;
  localparam int DEF_GRID_LOG2 = 5;
  localparam int N_PIX         = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESTORE,
    ST_READ,
    ST_CAPTURE,
    ST_DRAW,
    ST_DONE
`ifdef CURSOR_BLINK_EN
    , ST_BLINK
`endif
  } state_t;

  // Cross offset table: 0 centre, 1 left, 2 right, 3 up, 4 down.
  function automatic logic signed [1:0] cross_dx(input logic [2:0] idx);
    case (idx)
      3'd1:    return -2'sd1;
      3'd2:    return 2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

  function automatic logic signed [1:0] cross_dy(input logic [2:0] idx);
    case (idx)
      3'd3:    return -2'sd1;
      3'd4:    return 2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/cursor_shape_gen.sv
// Maps a cross index and centre to a framebuffer address, flagging pixels
// that fall outside the grid.
module cursor_shape_gen
  import paint_pkg::*;
#(
  parameter int GRID_LOG2 = DEF_GRID_LOG2
) (
  input  logic [2:0]             idx,
  input  logic [7:0]             cx,
  input  logic [7:0]             cy,
  output logic [2*GRID_LOG2-1:0] addr,
  output logic                   clipped
);

  localparam logic signed [9:0] GRID = 10'(1 << GRID_LOG2);

  logic signed [1:0] dx;
  logic signed [1:0] dy;
  logic signed [9:0] px;
  logic signed [9:0] py;

  always_comb begin
    dx = cross_dx(idx);
    dy = cross_dy(idx);
    // Ten signed bits hold -1 and 256, so both edges of the grid clip cleanly.
    px = $signed({2'b00, cx}) + $signed({{8{dx[1]}}, dx});
    py = $signed({2'b00, cy}) + $signed({{8{dy[1]}}, dy});
    clipped = (px < 10'sd0) || (px >= GRID) || (py < 10'sd0) || (py >= GRID) ||
              (idx > 3'd4);
    addr = clipped ? '0 : {py[GRID_LOG2-1:0], px[GRID_LOG2-1:0]};
  end

endmodule

// File: rtl/cursor_draw.sv
// Cursor overlay engine: restores the pixels under the old cross, saves the
// pixels under the new one, then paints it. CURSOR_BLINK_EN enables blinking.
module cursor_draw
  import paint_pkg::*;
#(
  parameter int          GRID_LOG2    = DEF_GRID_LOG2,
  parameter logic [7:0]  CURSOR_COLOR = 8'hFF,
  parameter logic [23:0] BLINK_DIV    = 24'd6_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             in_x,
  input  logic [7:0]             in_y,
  input  logic                   paint_we,
  input  logic [7:0]             paint_x,
  input  logic [7:0]             paint_y,
  input  logic [7:0]             paint_data,
  output logic                   fb_rd_en,
  output logic                   fb_wr_en,
  output logic [2*GRID_LOG2-1:0] fb_addr,
  output logic [7:0]             fb_wdata,
  input  logic [7:0]             fb_rdata,
  output logic                   done,
  output logic                   busy
);

  localparam int         AW    = 2 * GRID_LOG2;
  localparam logic [8:0] GRID9 = 9'(1 << GRID_LOG2);

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         cx_q, cx_d, cy_q, cy_d;
  logic [COLOR_W-1:0] sv_data_q [N_PIX];
  logic [COLOR_W-1:0] sv_data_d [N_PIX];
  logic [AW-1:0]      sv_addr_q [N_PIX];
  logic [AW-1:0]      sv_addr_d [N_PIX];
  logic [N_PIX-1:0]   sv_vld_q, sv_vld_d;

  logic [AW-1:0]      pix_addr;
  logic               pix_clip;
  logic [2:0]         prev_idx;
  logic               last_idx;
  logic               paint_in;
  logic [AW-1:0]      paint_addr;
  logic [N_PIX-1:0]   snoop_hit;

`ifdef CURSOR_BLINK_EN
  logic [23:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
`else
  logic unused_blink;
  assign unused_blink = ^BLINK_DIV;
`endif

  cursor_shape_gen #(.GRID_LOG2(GRID_LOG2)) u_shape (
    .idx     (idx_q),
    .cx      (cx_q),
    .cy      (cy_q),
    .addr    (pix_addr),
    .clipped (pix_clip)
  );

  assign prev_idx   = idx_q - 3'd1;
  assign last_idx   = (idx_q == 3'd4);
  assign paint_in   = ({1'b0, paint_x} < GRID9) && ({1'b0, paint_y} < GRID9);
  assign paint_addr = {paint_y[GRID_LOG2-1:0], paint_x[GRID_LOG2-1:0]};

  // A painter write over a saved pixel must update the copy we will restore.
  always_comb begin
    snoop_hit = '0;
    for (int i = 0; i < N_PIX; i++) begin
      snoop_hit[i] = paint_we && paint_in && sv_vld_q[i] && (sv_addr_q[i] == paint_addr);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    sv_data_d = sv_data_q;
    sv_addr_d = sv_addr_q;
    sv_vld_d  = sv_vld_q;
    fb_rd_en  = 1'b0;
    fb_wr_en  = 1'b0;
    fb_addr   = '0;
    fb_wdata  = '0;
    done      = 1'b0;
    busy      = (state_q != ST_IDLE);
`ifdef CURSOR_BLINK_EN
    cnt_d     = cnt_q;
    phase_d   = phase_q;
`endif

    case (state_q)
      ST_IDLE: begin
        for (int i = 0; i < N_PIX; i++) begin
          if (snoop_hit[i]) sv_data_d[i] = paint_data;
        end
        if (start) begin
          state_d = ST_RESTORE;
          idx_d   = 3'd0;
          cx_d    = in_x;
          cy_d    = in_y;
        end
`ifdef CURSOR_BLINK_EN
        else if (cnt_q == BLINK_DIV - 24'd1) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          if (|sv_vld_q) begin
            state_d = ST_BLINK;
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
`endif
      end

      ST_RESTORE: begin
        if (sv_vld_q[idx_q]) begin
          fb_wr_en = 1'b1;
          fb_addr  = sv_addr_q[idx_q];
          fb_wdata = sv_data_q[idx_q];
        end
        idx_d = last_idx ? 3'd0 : idx_q + 3'd1;
        if (last_idx) state_d = ST_READ;
      end

      ST_READ: begin
        sv_addr_d[idx_q] = pix_addr;
        sv_vld_d[idx_q]  = ~pix_clip;
        if (!pix_clip) begin
          fb_rd_en = 1'b1;
          fb_addr  = pix_addr;
        end
        // Read data lags its strobe by one cycle.
        if (idx_q != 3'd0 && sv_vld_q[prev_idx]) sv_data_d[prev_idx] = fb_rdata;
        idx_d = last_idx ? 3'd0 : idx_q + 3'd1;
        if (last_idx) state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        if (sv_vld_q[4]) sv_data_d[4] = fb_rdata;
        state_d = ST_DRAW;
      end

      ST_DRAW: begin
        if (sv_vld_q[idx_q]) begin
          fb_wr_en = 1'b1;
          fb_addr  = sv_addr_q[idx_q];
          fb_wdata = CURSOR_COLOR;
        end
`ifdef CURSOR_BLINK_EN
        phase_d = 1'b1;
        cnt_d   = '0;
`endif
        idx_d = last_idx ? 3'd0 : idx_q + 3'd1;
        if (last_idx) state_d = ST_DONE;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

`ifdef CURSOR_BLINK_EN
      ST_BLINK: begin
        for (int i = 0; i < N_PIX; i++) begin
          if (snoop_hit[i]) sv_data_d[i] = paint_data;
        end
        if (sv_vld_q[idx_q]) begin
          fb_wr_en = 1'b1;
          fb_addr  = sv_addr_q[idx_q];
          fb_wdata = phase_q ? CURSOR_COLOR : sv_data_q[idx_q];
        end
        idx_d = last_idx ? 3'd0 : idx_q + 3'd1;
        if (last_idx) state_d = ST_IDLE;
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // Reset abandons the sequence without touching memory on the reset edge.
    if (rst) begin
      fb_rd_en = 1'b0;
      fb_wr_en = 1'b0;
      fb_addr  = '0;
      fb_wdata = '0;
      done     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 3'd0;
      sv_vld_q <= '0;
      for (int i = 0; i < N_PIX; i++) begin
        sv_data_q[i] <= '0;
        sv_addr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sv_vld_q  <= sv_vld_d;
      sv_data_q <= sv_data_d;
      sv_addr_q <= sv_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    cx_q <= cx_d;
    cy_q <= cy_d;
  end

`ifdef CURSOR_BLINK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
`endif

endmodule

// File: tb/tb_cursor_draw.sv
// Directed bench for cursor_draw against a behavioural 32x32 framebuffer.
module tb_cursor_draw;

  localparam int G    = 5;
  localparam int AW   = 2 * G;
  localparam int NPIX = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    in_x, in_y;
  logic          paint_we;
  logic [7:0]    paint_x, paint_y, paint_data;
  logic          fb_rd_en, fb_wr_en;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_wdata;
  logic [7:0]    fb_rdata;
  logic          done, busy;

  cursor_draw #(.GRID_LOG2(G), .CURSOR_COLOR(8'hFF), .BLINK_DIV(24'd8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_x       (in_x),
    .in_y       (in_y),
    .paint_we   (paint_we),
    .paint_x    (paint_x),
    .paint_y    (paint_y),
    .paint_data (paint_data),
    .fb_rd_en   (fb_rd_en),
    .fb_wr_en   (fb_wr_en),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .fb_rdata   (fb_rdata),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Framebuffer: registered read, DUT and painter writes.
  logic [7:0] mem [NPIX];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NPIX; i++) mem[i] <= 8'h11;
    end else begin
      if (fb_wr_en) mem[fb_addr] <= fb_wdata;
      if (paint_we && paint_x < 8'd32 && paint_y < 8'd32)
        mem[{paint_y[G-1:0], paint_x[G-1:0]}] <= paint_data;
    end
    fb_rdata <= fb_rd_en ? mem[fb_addr] : 8'h00;
  end

  // Background image (what lies under the cursor) and current cursor.
  logic [7:0] ref_img [NPIX];
  int         cur_x, cur_y;
  bit         cur_valid;
  int         n_checks = 0;
  int         n_fail   = 0;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    bit         hold;
    int         n_rst;
    int         n_rd;
    int         n_draw;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int cross_addr(input int x, input int y, input int k);
    int dx [5] = '{0, -1, 1, 0, 0};
    int dy [5] = '{0, 0, 0, -1, 1};
    int px, py;
    px = x + dx[k];
    py = y + dy[k];
    if (px < 0 || px >= 32 || py < 0 || py >= 32) return -1;
    return py * 32 + px;
  endfunction

  task automatic check_image(input string tag);
    int         bad;
    logic [7:0] e;
    bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      e = ref_img[i];
      if (cur_valid)
        for (int k = 0; k < 5; k++) if (cross_addr(cur_x, cur_y, k) == i) e = 8'hFF;
      if (mem[i] !== e) bad++;
    end
    check({tag, "_image_bad_pixels"}, bad, 0);
  endtask

  task automatic run_row(input vec_t v, input string tag);
    int done_cyc, n_rst, n_rd, n_draw, a;
    bit bus_ok, acc_ok;
    done_cyc = 0; n_rst = 0; n_rd = 0; n_draw = 0;
    bus_ok = 1'b1; acc_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; in_x = v.x; in_y = v.y;
    for (int n = 1; n <= 40 && done_cyc == 0; n++) begin
      @(negedge clk);
      if (!v.hold || n >= 17) start = 1'b0;
      if (v.hold && n == 1) in_x = v.x + 8'd3;
      if (fb_rd_en && fb_wr_en) bus_ok = 1'b0;
      if (!fb_rd_en && !fb_wr_en && (fb_addr != '0 || fb_wdata != 8'h00)) bus_ok = 1'b0;
      if (busy !== (n <= 17)) bus_ok = 1'b0;
      if (fb_wr_en) begin
        if (n <= 5) begin
          n_rst++;
          a = cross_addr(cur_x, cur_y, n - 1);
          if (!cur_valid || a < 0 || int'(fb_addr) != a || fb_wdata !== ref_img[a]) acc_ok = 1'b0;
        end else if (n >= 12 && n <= 16) begin
          n_draw++;
          a = cross_addr(v.x, v.y, n - 12);
          if (a < 0 || int'(fb_addr) != a || fb_wdata !== 8'hFF) acc_ok = 1'b0;
        end else bus_ok = 1'b0;
      end
      if (fb_rd_en) begin
        if (n >= 6 && n <= 10) begin
          n_rd++;
          a = cross_addr(v.x, v.y, n - 6);
          if (a < 0 || int'(fb_addr) != a) acc_ok = 1'b0;
        end else bus_ok = 1'b0;
      end
      if (done) done_cyc = n;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, 17);
    check({tag, "_restore_writes"}, n_rst, v.n_rst);
    check({tag, "_reads"}, n_rd, v.n_rd);
    check({tag, "_draw_writes"}, n_draw, v.n_draw);
    check({tag, "_bus_rules"}, bus_ok, 1);
    check({tag, "_access_addr_data"}, acc_ok, 1);
    cur_x = v.x; cur_y = v.y; cur_valid = 1'b1;
    check_image(tag);
  endtask

  task automatic paint(input logic [7:0] x, input logic [7:0] y, input logic [7:0] d);
    @(negedge clk);
    paint_we = 1'b1; paint_x = x; paint_y = y; paint_data = d;
    @(negedge clk);
    paint_we = 1'b0;
    if (x < 8'd32 && y < 8'd32) ref_img[int'(y) * 32 + int'(x)] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    bit   ok;
    int   a;
    vecs[0] = '{x: 8'd5,   y: 8'd5,   hold: 1'b0, n_rst: 0, n_rd: 5, n_draw: 5};
    vecs[1] = '{x: 8'd10,  y: 8'd10,  hold: 1'b1, n_rst: 5, n_rd: 5, n_draw: 5};
    vecs[2] = '{x: 8'd0,   y: 8'd31,  hold: 1'b0, n_rst: 5, n_rd: 3, n_draw: 3};
    vecs[3] = '{x: 8'd0,   y: 8'd31,  hold: 1'b0, n_rst: 3, n_rd: 3, n_draw: 3};
    vecs[4] = '{x: 8'd31,  y: 8'd0,   hold: 1'b0, n_rst: 3, n_rd: 3, n_draw: 3};
    vecs[5] = '{x: 8'd200, y: 8'd200, hold: 1'b0, n_rst: 3, n_rd: 0, n_draw: 0};
    vecs[6] = '{x: 8'd32,  y: 8'd5,   hold: 1'b0, n_rst: 0, n_rd: 1, n_draw: 1};
    vecs[7] = '{x: 8'd10,  y: 8'd10,  hold: 1'b0, n_rst: 1, n_rd: 5, n_draw: 5};

    for (int i = 0; i < NPIX; i++) ref_img[i] = 8'h11;
    cur_x = 0; cur_y = 0; cur_valid = 1'b0;
    rst = 1'b1; mem_init = 1'b1; start = 1'b0; in_x = '0; in_y = '0;
    paint_we = 1'b0; paint_x = '0; paint_y = '0; paint_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {done, busy, fb_rd_en, fb_wr_en, fb_addr, fb_wdata}, 0);
    rst = 1'b0; mem_init = 1'b0;

    for (int i = 0; i < 8; i++) run_row(vecs[i], $sformatf("row%0d", i));

    // Out-of-grid paint must not alias onto (9,10); in-grid paint is snooped.
    paint(8'd41, 8'd10, 8'h77);
    paint(8'd10, 8'd10, 8'h2A);
    hv = '{x: 8'd3, y: 8'd3, hold: 1'b0, n_rst: 5, n_rd: 5, n_draw: 5};
    run_row(hv, "snoop");
    check("snoop_pixel_10_10", mem[10 * 32 + 10], 8'h2A);
    check("snoop_pixel_9_10", mem[10 * 32 + 9], 8'h11);

    // Reset during DRAW cycle 2 (overall cycle 13).
    @(negedge clk);
    start = 1'b1; in_x = 8'd20; in_y = 8'd20;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {done, busy, fb_rd_en, fb_wr_en, fb_addr, fb_wdata}, 0);
    rst = 1'b0;
    check("midrst_pixel_19_20", mem[20 * 32 + 19], 8'h11);
    ref_img[20 * 32 + 20] = 8'hFF;
    cur_valid = 1'b0;
    check_image("midrst");
    hv = '{x: 8'd7, y: 8'd7, hold: 1'b0, n_rst: 0, n_rd: 5, n_draw: 5};
    run_row(hv, "after_rst");

`ifdef CURSOR_BLINK_EN
    begin
      int n0, n1;
      bit bok;
      n0 = 0; n1 = 0; bok = 1'b1;
      for (int n = 1; n <= 30; n++) begin
        @(negedge clk);
        if (fb_wr_en) begin
          if (n >= 9 && n <= 13) begin
            a = cross_addr(7, 7, n - 9);
            if (int'(fb_addr) == a && fb_wdata === ref_img[a]) n0++;
          end else if (n >= 22 && n <= 26) begin
            a = cross_addr(7, 7, n - 22);
            if (int'(fb_addr) == a && fb_wdata === 8'hFF) n1++;
          end else bok = 1'b0;
        end
        if (fb_rd_en) bok = 1'b0;
      end
      check("blink_saved_writes", n0, 5);
      check("blink_color_writes", n1, 5);
      check("blink_no_stray_access", bok, 1);
    end
`endif

    ok = (n_fail == 0);
    if (!ok) a = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
